// File: rtl/sp_register_pkg.sv
// sp_register_pkg: shared widths, reset/limit defaults and the per-edge control decode.
// Bounds checking is enabled by defining SP_BOUNDS_CHECK_EN (see sp_register.sv).
`ifndef SP_REGISTER_DEFINES
`define SP_REGISTER_DEFINES
`define DATA_WIDTH 8
`define SP_TOP 16'hFFFF
`define SP_LIMIT 16'hFF00
`endif

package sp_register_pkg;

  localparam int unsigned SpAddrWidth = 2 * `DATA_WIDTH;

  typedef enum logic [1:0] {
    OpHold,
    OpLoad,
    OpPush,
    OpPop
  } sp_op_e;

  // Priority: chip select, then byte loads, then push/pop (both together cancel).
  function automatic sp_op_e decode_op(logic cs, logic we_any, logic push, logic pop);
    if (!cs) return OpHold;
    if (we_any) return OpLoad;
    if (push && !pop) return OpPush;
    if (pop && !push) return OpPop;
    return OpHold;
  endfunction

endpackage

// File: rtl/sp_register_if.sv
// sp_register_if: control strobes and status flags of the stack pointer.
// The tri-state data/address nets stay as plain ports on the top.
interface sp_register_if;
  logic CS;
  logic OE_A;
  logic PUSH;
  logic POP;
  logic WE_L;
  logic WE_H;
  logic OE_L;
  logic OE_H;
  logic overflow;
  logic underflow;

  modport master (
    output CS, OE_A, PUSH, POP, WE_L, WE_H, OE_L, OE_H,
    input  overflow, underflow
  );

  modport slave (
    input  CS, OE_A, PUSH, POP, WE_L, WE_H, OE_L, OE_H,
    output overflow, underflow
  );
endinterface

// File: rtl/sp_register_updown_counter.sv
// updown_counter: loadable up/down counter slice with ripple carry/borrow out.
module updown_counter #(
  parameter int unsigned      WIDTH     = `DATA_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EN,
  input  logic             DIR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             carry_out
);

  logic [WIDTH-1:0] q_d;

  // Next value: a load wins over counting; DIR=1 counts up.
  always_comb begin
    q_d = Q;
    if (LOAD) begin
      q_d = D;
    end else if (EN) begin
      q_d = DIR ? Q + WIDTH'(1) : Q - WIDTH'(1);
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Q <= RESET_VAL;
    end else begin
      Q <= q_d;
    end
  end

  // Enables the next slice in the same edge when this slice wraps.
  assign carry_out = EN & (DIR ? (Q == '1) : (Q == '0));

endmodule

// File: rtl/sp_register.sv
// sp_register: 16-bit stack pointer built from two 8-bit counter halves.
// Push counts down, pop counts up; SP points at the next free slot.
// Optional macro SP_BOUNDS_CHECK_EN: blocks push at SP_LIMIT / pop when empty and
// raises sticky overflow/underflow flags; without it SP wraps and flags read 0.
module sp_register
  import sp_register_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = SpAddrWidth,
  parameter logic [ADDR_WIDTH-1:0] SP_TOP     = `SP_TOP
`ifdef SP_BOUNDS_CHECK_EN
  ,
  parameter logic [ADDR_WIDTH-1:0] SP_LIMIT   = `SP_LIMIT
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  sp_register_if.slave              bus,
  inout  wire  [ADDR_WIDTH/2-1:0]   data,
  output wire  [ADDR_WIDTH-1:0]     address
);

  localparam int unsigned DATA_WIDTH = ADDR_WIDTH / 2;

  sp_op_e                op;
  logic                  we_any;
  logic                  load_l;
  logic                  load_h;
  logic                  count_en;
  logic                  count_up;
  logic                  carry_l;
  logic                  unused_carry_h;
  logic                  push_blocked;
  logic                  pop_blocked;
  logic [DATA_WIDTH-1:0] sp_lo;
  logic [DATA_WIDTH-1:0] sp_hi;
  logic [ADDR_WIDTH-1:0] sp;
  logic [ADDR_WIDTH-1:0] addr_val;
  logic [DATA_WIDTH-1:0] data_val;
  logic                  data_en;

  assign sp = {sp_hi, sp_lo};

  // Decode this edge's operation and the counter controls.
  always_comb begin
    we_any   = bus.WE_L | bus.WE_H;
    op       = decode_op(bus.CS, we_any, bus.PUSH, bus.POP);
    load_l   = (op == OpLoad) & bus.WE_L;
    load_h   = (op == OpLoad) & bus.WE_H;
    count_up = (op == OpPop);
    count_en = ((op == OpPush) & ~push_blocked) | ((op == OpPop) & ~pop_blocked);
  end

  updown_counter #(
    .WIDTH     (DATA_WIDTH),
    .RESET_VAL (SP_TOP[DATA_WIDTH-1:0])
  ) u_lo (
    .clk       (clk),
    .reset     (reset),
    .EN        (count_en),
    .DIR       (count_up),
    .LOAD      (load_l),
    .D         (data),
    .Q         (sp_lo),
    .carry_out (carry_l)
  );

  // High half only moves when the low half wraps in the counting direction.
  updown_counter #(
    .WIDTH     (DATA_WIDTH),
    .RESET_VAL (SP_TOP[ADDR_WIDTH-1:DATA_WIDTH])
  ) u_hi (
    .clk       (clk),
    .reset     (reset),
    .EN        (carry_l),
    .DIR       (count_up),
    .LOAD      (load_h),
    .D         (data),
    .Q         (sp_hi),
    .carry_out (unused_carry_h)
  );

`ifdef SP_BOUNDS_CHECK_EN
  logic overflow_q;
  logic underflow_q;

  assign push_blocked = (sp == SP_LIMIT);
  assign pop_blocked  = (sp == SP_TOP);

  // Sticky flags: set by a blocked push/pop, cleared only by reset or a byte load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (op == OpLoad) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if ((op == OpPush) && push_blocked) overflow_q  <= 1'b1;
      if ((op == OpPop) && pop_blocked)   underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign push_blocked  = 1'b0;
  assign pop_blocked   = 1'b0;
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  // Bus drive values: a pop presents SP+1 (even when blocked); OE_L wins over OE_H.
  always_comb begin
    addr_val = (bus.CS & bus.POP & ~bus.PUSH) ? sp + ADDR_WIDTH'(1) : sp;
    data_en  = bus.CS & (bus.OE_L | bus.OE_H);
    data_val = bus.OE_L ? sp_lo : sp_hi;
  end

  assign address = bus.OE_A ? addr_val : {ADDR_WIDTH{1'bz}};
  assign data    = data_en ? data_val : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sp_register.sv
// tb_sp_register: vector table plus hand-written sequences for sp_register.
// Released tri-state nets are pulled high, so high-Z reads back as all ones.
module tb_sp_register;
  import sp_register_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sp_register_if bus_if ();
  tri1 [7:0]  data;
  tri1 [15:0] address;
  logic       tb_drv;
  logic [7:0] tb_din;

  assign data = tb_drv ? tb_din : 8'hzz;

  sp_register dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .data    (data),
    .address (address)
  );

  typedef struct {
    logic       cs;
    logic       push;
    logic       pop;
    logic       we_l;
    logic       we_h;
    logic [7:0] din;
    logic [15:0] exp_sp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  vec_t vecs[13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_ctrl(input logic cs, input logic oea, input logic push, input logic pop,
                          input logic wel, input logic weh, input logic oel, input logic oeh,
                          input logic drv, input logic [7:0] din);
    bus_if.CS   = cs;
    bus_if.OE_A = oea;
    bus_if.PUSH = push;
    bus_if.POP  = pop;
    bus_if.WE_L = wel;
    bus_if.WE_H = weh;
    bus_if.OE_L = oel;
    bus_if.OE_H = oeh;
    tb_drv      = drv;
    tb_din      = din;
  endtask

  task automatic idle();
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Pop the oldest expected SP and compare it with the idle address (= SP).
  task automatic check_sp(input string name);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", name, address);
    end else begin
      chk(name, address, exp_q.pop_front());
    end
  endtask

  // One clocked operation: drive at negedge, record expectation, check after the edge.
  task automatic cycle(input logic cs, input logic push, input logic pop, input logic wel,
                       input logic weh, input logic [7:0] din, input logic [15:0] exp_sp,
                       input string name);
    @(negedge clk);
    set_ctrl(cs, 1'b1, push, pop, wel, weh, 1'b0, 1'b0, wel | weh, din);
    exp_q.push_back(exp_sp);
    @(posedge clk);
    #1 idle();
    #1 check_sp(name);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'hFF00};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 16'h0100};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h00FF};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h00FE};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h00FF};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0100};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0100};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 16'h0100};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAB, 16'hABAB};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hF0, 16'hABF0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 16'hFFF0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'hFFF1};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFF0};

    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sp", address, 16'hFFFF);
    chk("reset_ovf", {15'd0, bus_if.overflow}, 16'h0000);
    chk("reset_unf", {15'd0, bus_if.underflow}, 16'h0000);
    chk("reset_data_hiz", {8'h00, data}, 16'h00FF);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].cs, vecs[i].push, vecs[i].pop, vecs[i].we_l, vecs[i].we_h, vecs[i].din,
            vecs[i].exp_sp, $sformatf("vec%0d", i));
    end

    // Pop address is combinational; push+pop cancels back to SP. SP is FFF0 here.
    @(negedge clk);
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1 chk("pop_addr_comb", address, 16'hFFF1);
    bus_if.PUSH = 1'b1;
    #1 chk("pushpop_addr", address, 16'hFFF0);
    bus_if.PUSH = 1'b0;
    exp_q.push_back(16'hFFF1);
    @(posedge clk);
    #1 idle();
    #1 check_sp("pop_edge");

    // Byte reads, OE priority, CS gating of the data drive, address release.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'hFF00, "load_lo00");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 16'h0100, "load_hi01");
    @(negedge clk);
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    #1 chk("read_lo", {8'h00, data}, 16'h0000);
    bus_if.OE_L = 1'b0;
    bus_if.OE_H = 1'b1;
    #1 chk("read_hi", {8'h00, data}, 16'h0001);
    bus_if.OE_L = 1'b1;
    #1 chk("read_both_lo_wins", {8'h00, data}, 16'h0000);
    bus_if.CS = 1'b0;
    #1 chk("read_cs0_hiz", {8'h00, data}, 16'h00FF);
    bus_if.OE_A = 1'b0;
    #1 chk("addr_hiz", address, 16'hFFFF);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h00FF, "push_borrow");

`ifdef SP_BOUNDS_CHECK_EN
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, "load_lo_lim");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 16'hFF00, "load_hi_lim");
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFF00, "push_at_limit");
    chk("ovf_set", {15'd0, bus_if.overflow}, 16'h0001);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'hFF01, "pop_above_limit");
    chk("ovf_sticky", {15'd0, bus_if.overflow}, 16'h0001);
`else
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 16'h0000, "load_zero");
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFF, "push_wrap");
    chk("ovf_tied0", {15'd0, bus_if.overflow}, 16'h0000);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, "pop_wrap");
    chk("unf_tied0", {15'd0, bus_if.underflow}, 16'h0000);
`endif

    // Asynchronous reset in the middle of a push cycle with SP=1234.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h34, (address & 16'hFF00) | 16'h0034, "load_34");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h1234, "load_12");
    @(negedge clk);
    set_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_sp", address, 16'hFFFF);
    chk("async_reset_ovf", {15'd0, bus_if.overflow}, 16'h0000);
    chk("async_reset_unf", {15'd0, bus_if.underflow}, 16'h0000);
    chk("async_reset_data", {8'h00, data}, 16'h00FF);
    @(posedge clk);
    #1 chk("reset_hold", address, 16'hFFFF);
    @(negedge clk);
    idle();
    reset = 1'b1;

`ifdef SP_BOUNDS_CHECK_EN
    // Blocked pop when empty still shows SP+1 on the address bus.
    @(negedge clk);
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1 chk("blocked_pop_addr", address, 16'h0000);
    exp_q.push_back(16'hFFFF);
    @(posedge clk);
    #1 idle();
    #1 check_sp("pop_when_empty");
    chk("unf_set", {15'd0, bus_if.underflow}, 16'h0001);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFE, "push_after_unf");
    chk("unf_sticky", {15'd0, bus_if.underflow}, 16'h0001);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'hFF00, "load_clears");
    chk("unf_cleared", {15'd0, bus_if.underflow}, 16'h0000);
    chk("ovf_cleared", {15'd0, bus_if.overflow}, 16'h0000);
`else
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, "pop_after_reset_wrap");
    chk("unf_after_reset", {15'd0, bus_if.underflow}, 16'h0000);
`endif

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
